lcd_cmd_sequencer: RTL

//  Parametrised command front-end for lcd_controller: buffers host LCD commands {rs,data,delay} in a FIFO,

---
 rtl/lcd_cmd_sequencer_pkg.sv | 39 +++
 rtl/lcd_cmd_sequencer_if.sv | 21 ++
 rtl/lcd_cmd_fifo.sv | 47 ++++
 rtl/lcd_cmd_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lcd_cmd_sequencer_pkg.sv
// Shared types for the LCD command sequencer.
// Holds the FSM encoding, FIFO entry layout and the power-up init script.
package lcd_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DELAY = 3'd5
    } state_e;

    // FIFO entry is {rs, data[7:0], delay_us}
    localparam int ENT_RS_W   = 1;
    localparam int ENT_DATA_W = 8;
    localparam int ROM_LEN    = 4;

    function automatic logic [8:0] rom_cmd(input logic [2:0] idx);
        logic [8:0] c;
        case (idx)
            3'd0:    c = 9'h028;
            3'd1:    c = 9'h006;
            3'd2:    c = 9'h00C;
            default: c = 9'h001;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] rom_delay(input logic [2:0] idx);
        logic [15:0] d;
        case (idx)
            3'd3:    d = 16'd1640;
            default: d = 16'd40;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Host command handshake into the LCD sequencer.
// master = command producer, slave = sequencer.
interface lcd_cmd_sequencer_if #(
    parameter int DELAY_W = 11
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_rs;
    logic [7:0]         cmd_data;
    logic [DELAY_W-1:0] cmd_delay_us;

    modport master (
        output cmd_valid, cmd_rs, cmd_data, cmd_delay_us,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_rs, cmd_data, cmd_delay_us,
        output cmd_ready
    );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with occupancy, full and empty flags.
// Read data is first-word fall-through from the head entry.
module lcd_cmd_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   level_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            if (push_i && !pop_i)      level_q <= level_q + (AW+1)'(1);
            else if (!push_i && pop_i) level_q <= level_q - (AW+1)'(1);
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// LCD command front-end: queues host commands, runs the init script,
// strobes each command into lcd_controller and enforces settle delays.
module lcd_cmd_sequencer
    import lcd_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int DELAY_W       = 11,
    parameter int US_TICKS      = 50,
    parameter int CLK_PERIOD_NS = 20,
    parameter int TIMEOUT_CYC   = 4096,
    parameter int INIT_EN       = 1,
    parameter int POWERUP_US    = 15000
) (
    input  logic                          clk,
    input  logic                          rst,
    lcd_cmd_sequencer_if.slave            cmd_if,
    output logic                          ctl_rs_o,
    output logic [7:0]                    ctl_data_o,
    output logic                          ctl_strobe_o,
    output logic [7:0]                    ctl_period_ns_o,
    input  logic                          ctl_done_i,
    output logic                          busy_o,
    output logic                          init_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          timeout_err_o
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = ENT_RS_W + ENT_DATA_W + DELAY_W;
    localparam int PW  = $clog2(US_TICKS + 1);
    localparam int PUW = $clog2(POWERUP_US + 1);
    localparam int UW  = (PUW > DELAY_W) ? PUW : DELAY_W;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q;
    logic [PW-1:0]      presc_q;
    logic [UW-1:0]      us_q;
    logic [TW-1:0]      tmo_q;
    logic [2:0]         rom_idx_q;
    logic               rs_q;
    logic [7:0]         data_q;
    logic [DELAY_W-1:0] delay_q;
    logic               strobe_q;
    logic               init_done_q;
    logic               tmo_err_q;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [FW-1:0]      rdata;
    logic [AW:0]        level;
    logic               us_tick;
    logic               pwr_done;
    logic               dly_done;
    state_e             after_cmd;

    assign cmd_if.cmd_ready = ~rst & ~full;
    assign push = cmd_if.cmd_valid & cmd_if.cmd_ready;
    assign pop  = (state_q == ST_IDLE) & ~empty;

    assign us_tick  = (presc_q == PW'(US_TICKS - 1));
    assign pwr_done = us_tick && (us_q == UW'(POWERUP_US - 1));
    assign dly_done = (delay_q == '0) ||
                      (us_tick && (us_q + UW'(1) == UW'(delay_q)));
    assign after_cmd = init_done_q ? ST_IDLE : ST_INIT;

    lcd_cmd_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cmd_if.cmd_rs, cmd_if.cmd_data, cmd_if.cmd_delay_us}),
        .rdata_o (rdata),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (INIT_EN != 0) ? ST_PWRUP : ST_IDLE;
            presc_q     <= '0;
            us_q        <= '0;
            tmo_q       <= '0;
            rom_idx_q   <= '0;
            rs_q        <= 1'b0;
            data_q      <= '0;
            delay_q     <= '0;
            strobe_q    <= 1'b0;
            init_done_q <= (INIT_EN == 0);
            tmo_err_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (state_q == ST_PWRUP || state_q == ST_DELAY) begin
                if (us_tick) begin
                    presc_q <= '0;
                    us_q    <= us_q + UW'(1);
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
            unique case (state_q)
                ST_PWRUP: if (pwr_done) state_q <= ST_INIT;
                ST_INIT: begin
                    if (rom_idx_q == 3'(ROM_LEN)) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        {rs_q, data_q} <= rom_cmd(rom_idx_q);
                        delay_q   <= DELAY_W'(rom_delay(rom_idx_q));
                        rom_idx_q <= rom_idx_q + 3'd1;
                        strobe_q  <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_IDLE: begin
                    if (pop) begin
                        {rs_q, data_q, delay_q} <= rdata;
                        strobe_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                // a stuck controller aborts the command but never the script
                ST_WAIT: begin
                    if (ctl_done_i) begin
                        presc_q <= '0;
                        us_q    <= '0;
                        state_q <= ST_DELAY;
                    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= after_cmd;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_DELAY: if (dly_done) state_q <= after_cmd;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign ctl_rs_o        = rs_q;
    assign ctl_data_o      = data_q;
    assign ctl_strobe_o    = strobe_q;
    assign ctl_period_ns_o = 8'(CLK_PERIOD_NS);
    assign busy_o          = (state_q != ST_IDLE) | ~empty;
    assign init_done_o     = init_done_q;
    assign fifo_level_o    = level;
    assign timeout_err_o   = tmo_err_q;

endmodule
